polydiv_sequencer: RTL
======================

# polydiv_sequencer

Iteration controller for the polynomial long-division subtract stage in the SNTRUP757 arithmetic path. It launches the subtract/shift datapath once per division step and tracks the falling remainder degree after each step. It ping-pongs the remainder between two coefficient banks and stops when the remainder degree drops below the divisor degree. It sits between the top-level scheduler (`start`/`done`) and one subtract stage (`sub_start`/`sub_done`).

## Interface
- `DEG_W`, 11: width of all degree and iteration values.
- `MAX_ITER`, 757: iteration cap. Reaching it is an error.
- `TIMEOUT_CYCLES`, 4096: watchdog limit per step. Used only with the macro.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a division. Sampled only in IDLE.
- `deg_n` in DEG_W: numerator degree. Latched on an accepted `start`.
- `deg_d` in DEG_W: divisor degree. Latched on an accepted `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of a division, whether it succeeded or failed.
- `err` out 1: sticky. Cleared by an accepted `start` or by `rst`.
- `iter_count` out DEG_W: number of completed subtract steps.
- `rem_deg` out DEG_W: current remainder degree.
- `sub_start` out 1: one-cycle launch pulse to the subtract stage.
- `sub_deg_n` out DEG_W: numerator degree for the current step, equal to `rem_deg`.
- `sub_deg_d` out DEG_W: latched divisor degree.
- `sub_done` in 1: step-complete pulse from the subtract stage.
- `sub_deg` in DEG_W: new remainder degree. Valid in the cycle `sub_done` is high.
- `bank_sel` out 1: 0 = read bank A, write bank B. 1 = the reverse.

## Operation
- FSM states: IDLE, CHECK, LAUNCH, WAIT, SWAP, FINISH, FAIL.
- IDLE:
  - `start=1` latches `deg_n`→`rem_deg` and `deg_d`→`sub_deg_d`.
  - It also clears `iter_count`, `bank_sel` and `err`, then goes to CHECK.
  - `start` in any other state is ignored.
- CHECK, evaluated in this priority order:
  - `rem_deg < sub_deg_d` → FINISH.
  - `iter_count == MAX_ITER` → FAIL.
  - Otherwise → LAUNCH.
- LAUNCH: `sub_start=1` for exactly this cycle, then WAIT.
- WAIT:
  - Holds until `sub_done=1`.
  - If `sub_deg < rem_deg`, capture `sub_deg` into `rem_deg` and go to SWAP.
  - Otherwise (no strict decrease) → FAIL, with `rem_deg` unchanged.
- SWAP: toggle `bank_sel`, increment `iter_count`, then CHECK.
- FINISH: `done=1` for one cycle, then IDLE.
- FAIL: set `err=1`, pulse `done=1` for one cycle, then IDLE.
- `sub_done` outside WAIT is ignored.
- `iter_count` saturates and never wraps, because the MAX_ITER check precedes LAUNCH.
- Reset values: state IDLE. All outputs are 0, including `busy`, `done`, `err`, `sub_start`, `bank_sel`, `rem_deg`, `iter_count`, `sub_deg_n` and `sub_deg_d`.

## Timing
- All outputs are Moore (registered state or registers). There is no combinational path from input to output.
- `start` is accepted at edge t:
  - CHECK runs in cycle t+1.
  - If the division needs no step, `done` is high in cycle t+2.
  - Otherwise `sub_start` is high in cycle t+2.
- `sub_done` sampled at edge k:
  - SWAP in cycle k+1.
  - CHECK in cycle k+2.
  - Next `sub_start` in cycle k+3, or `done` in cycle k+3.
- The step-to-step overhead is 4 cycles plus the subtract latency.
- `sub_deg_n` is stable from LAUNCH until the next SWAP.
- `bank_sel` changes only in SWAP. It is never changed while the subtract stage is active.
- After the `done` pulse, `rem_deg`, `iter_count`, `bank_sel` and `err` hold until the next accepted `start`.
- `rst` asserted in any state, including mid-WAIT: IDLE at the next edge and all outputs return to reset values. A `sub_done` that arrives after the reset is ignored.

## Configuration
- `POLYDIV_TIMEOUT_EN` defined:
  - A per-step counter starts at 0 in LAUNCH and increments in every WAIT cycle.
  - Reaching `TIMEOUT_CYCLES` without `sub_done` → FAIL, giving `err=1` and a `done` pulse.
- `POLYDIV_TIMEOUT_EN` undefined: no counter. WAIT waits indefinitely.

## Structure
- Package `polydiv_pkg`:
  - FSM state enum.
  - Default `DEG_W`, `MAX_ITER` and `TIMEOUT_CYCLES` constants.
  - Degree typedef `deg_t` = logic [DEG_W-1:0].
- Sub-module `polydiv_watchdog`: the clear/count/expire timeout counter. It is instantiated only under `POLYDIV_TIMEOUT_EN`.

## Test plan
- `deg_n=10`, `deg_d=3`, and a subtract model that returns `sub_deg = sub_deg_n - 1` after 5 cycles:
  - exactly 8 `sub_start` pulses;
  - a single `done` pulse;
  - `rem_deg=2`, `iter_count=8`, `bank_sel=0`, `err=0`.
- `deg_n=2`, `deg_d=5`: `done` two cycles after `start`, with no `sub_start`, `iter_count=0` and `rem_deg=2`.
- `deg_n=6`, `deg_d=2`, and the model returns `sub_deg=6` on the first step: FAIL, `err=1`, a single `done` pulse and `rem_deg=6`.
- Reset mid-run:
  - `rst` pulsed during WAIT of step 3 of a `deg_n=20`, `deg_d=1` run → all outputs 0 at the next edge.
  - A late `sub_done` afterwards has no effect.
  - A new `start` then runs cleanly.
- `start` re-asserted while `busy=1`: ignored, and the first run's results are unaffected.
- With `POLYDIV_TIMEOUT_EN` and `TIMEOUT_CYCLES=16`, the model never answers:
  - `err=1` and `done` high 16 cycles after entering WAIT.
  - Without the macro, the FSM is still in WAIT after 10000 cycles.

Source files
------------

// File: rtl/polydiv_pkg.sv
// Shared types and default constants for the polynomial long-division sequencer.
package polydiv_pkg;

  localparam int DEF_DEG_W          = 11;
  localparam int DEF_MAX_ITER       = 757;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  typedef logic [DEF_DEG_W-1:0] deg_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_SWAP   = 3'd4,
    S_FINISH = 3'd5,
    S_FAIL   = 3'd6
  } state_t;

endpackage

// File: rtl/polydiv_watchdog.sv
// Per-step timeout counter: cleared at launch, counts while waiting, flags the last allowed cycle.
module polydiv_watchdog
  import polydiv_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_count && (r_cnt != CW'(LIMIT))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Expiry is raised in the LIMIT-th waiting cycle so the FSM leaves on the following edge.
  assign o_expired = i_count && (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/polydiv_sequencer.sv
// Iteration controller for the polynomial long-division subtract stage.
// Optional per-step watchdog enabled by defining POLYDIV_TIMEOUT_EN.
module polydiv_sequencer
  import polydiv_pkg::*;
#(
  parameter int DEG_W          = DEF_DEG_W,
  parameter int MAX_ITER       = DEF_MAX_ITER,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [DEG_W-1:0] i_deg_n,
  input  logic [DEG_W-1:0] i_deg_d,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [DEG_W-1:0] o_iter_count,
  output logic [DEG_W-1:0] o_rem_deg,
  output logic             o_sub_start,
  output logic [DEG_W-1:0] o_sub_deg_n,
  output logic [DEG_W-1:0] o_sub_deg_d,
  input  logic             i_sub_done,
  input  logic [DEG_W-1:0] i_sub_deg,
  output logic             o_bank_sel,
  output state_t           o_dbg_state
);

  // Handshake: o_sub_start is a one-cycle launch pulse; the stage answers later with a
  // one-cycle i_sub_done carrying i_sub_deg. i_sub_done is only honoured in S_WAIT.

  state_t           r_state;
  state_t           w_next;
  logic [DEG_W-1:0] r_rem_deg;
  logic [DEG_W-1:0] r_deg_d;
  logic [DEG_W-1:0] r_iter;
  logic             r_bank;
  logic             r_err;
  logic             w_load;
  logic             w_capture;
  logic             w_timeout;

`ifdef POLYDIV_TIMEOUT_EN
  polydiv_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (r_state == S_LAUNCH),
    .i_count   (r_state == S_WAIT),
    .o_expired (w_timeout)
  );
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign w_timeout            = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next = S_CHECK;
          w_load = 1'b1;
        end
      end
      S_CHECK: begin
        if (r_rem_deg < r_deg_d) begin
          w_next = S_FINISH;
        end else if (r_iter == DEG_W'(MAX_ITER)) begin
          w_next = S_FAIL;
        end else begin
          w_next = S_LAUNCH;
        end
      end
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT: begin
        // A step that does not strictly lower the degree would never terminate.
        if (i_sub_done) begin
          if (i_sub_deg < r_rem_deg) begin
            w_next    = S_SWAP;
            w_capture = 1'b1;
          end else begin
            w_next = S_FAIL;
          end
        end else if (w_timeout) begin
          w_next = S_FAIL;
        end
      end
      S_SWAP:   w_next = S_CHECK;
      S_FINISH: w_next = S_IDLE;
      S_FAIL:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_rem_deg <= '0;
      r_deg_d   <= '0;
      r_iter    <= '0;
      r_bank    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_rem_deg <= i_deg_n;
        r_deg_d   <= i_deg_d;
        r_iter    <= '0;
        r_bank    <= 1'b0;
        r_err     <= 1'b0;
      end
      if (w_capture) begin
        r_rem_deg <= i_sub_deg;
      end
      if (r_state == S_SWAP) begin
        r_bank <= ~r_bank;
        r_iter <= r_iter + 1'b1;
      end
      // Raised on entry so err is already visible alongside the done pulse.
      if (w_next == S_FAIL) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = (r_state == S_FINISH) || (r_state == S_FAIL);
  assign o_sub_start  = (r_state == S_LAUNCH);
  assign o_err        = r_err;
  assign o_iter_count = r_iter;
  assign o_rem_deg    = r_rem_deg;
  assign o_sub_deg_n  = r_rem_deg;
  assign o_sub_deg_d  = r_deg_d;
  assign o_bank_sel   = r_bank;
  assign o_dbg_state  = r_state;

endmodule
